rggen_register_responder: RTL and testbench

//  Responder (slave) end of rggen_register_if: decodes one register address, accepts

---
 rtl/rggen_register_responder.sv | 112 +++++++++++
 tb/tb_rggen_register_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rggen_register_responder.sv
// Single-register responder on the rggen register bus: address decode, programmable
// wait states, one-cycle ready/status response, and the register storage itself.
module rggen_register_responder #(
    parameter int                         ADDRESS_WIDTH = 16,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   START_ADDRESS = '0,
    parameter int                         WAIT_CYCLES   = 0,
    parameter bit                         READABLE      = 1'b1,
    parameter bit                         WRITABLE      = 1'b1,
    parameter logic [DATA_WIDTH-1:0]      INITIAL_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      request,
    input  logic [ADDRESS_WIDTH-1:0]  address,
    input  logic                      direction,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   write_strobe,
    output logic                      select,
    output logic                      ready,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic [1:0]                status,
    output logic [DATA_WIDTH-1:0]     value,
    input  logic                      i_hw_write,
    input  logic [DATA_WIDTH-1:0]     i_hw_write_data,
    output logic [DATA_WIDTH-1:0]     o_value
);

    localparam int         BYTES             = DATA_WIDTH / 8;
    localparam int         LSB               = $clog2(BYTES);
    localparam logic [1:0] RGGEN_OKAY        = 2'b00;
    localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
    localparam logic       RGGEN_READ        = 1'b0;
    localparam logic       RGGEN_WRITE       = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                 state;
    logic [7:0]             count;
    logic                   dir_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BYTES-1:0]       strb_q;
    logic [DATA_WIDTH-1:0]  value_q;

    logic                   dir_n;
    logic                   access_err;
    logic                   enter_resp;
    logic                   commit;

    // Byte-offset bits drop out of the compare after the shift.
    assign select = request && (((address ^ START_ADDRESS) >> LSB) == '0);

    // With zero wait states the response is built from the live bus direction,
    // since the latched copy is only loaded on the same edge.
    assign dir_n      = (state == ST_IDLE) ? direction : dir_q;
    assign access_err = (dir_n == RGGEN_WRITE) ? !WRITABLE : !READABLE;
    assign enter_resp = ((state == ST_IDLE) && select && (WAIT_CYCLES == 0)) ||
                        ((state == ST_WAIT) && (count == 8'd1));
    assign commit     = (state == ST_RESP) && (dir_q == RGGEN_WRITE) && WRITABLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            dir_q     <= RGGEN_READ;
            wdata_q   <= '0;
            strb_q    <= '0;
            ready     <= 1'b0;
            read_data <= '0;
            status    <= RGGEN_OKAY;
        end else begin
            ready     <= enter_resp;
            status    <= (enter_resp && access_err) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
            read_data <= (enter_resp && !access_err && (dir_n == RGGEN_READ)) ? value_q : '0;
            case (state)
                ST_IDLE: begin
                    if (select) begin
                        dir_q   <= direction;
                        wdata_q <= write_data;
                        strb_q  <= write_strobe;
                        count   <= 8'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    count <= count - 8'd1;
                    if (count == 8'd1) state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus write owns strobed bytes on the commit edge; a hw update fills the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= INITIAL_VALUE;
        end else begin
            for (int b = 0; b < BYTES; b++) begin
                if (commit && strb_q[b])
                    value_q[8*b +: 8] <= wdata_q[8*b +: 8];
                else if (i_hw_write)
                    value_q[8*b +: 8] <= i_hw_write_data[8*b +: 8];
            end
        end
    end

    assign value   = value_q;
    assign o_value = value_q;

endmodule

// File: tb/tb_rggen_register_responder.sv
// Scoreboarded bench for rggen_register_responder: three instances cover zero wait,
// multi-cycle wait, and an access-disabled register.
module tb_rggen_register_responder;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SERR = 2'b10;
    localparam logic       RD   = 1'b0;
    localparam logic       WR   = 1'b1;

    localparam int          CFG_WAIT [3] = '{0, 3, 0};
    localparam bit          CFG_RD   [3] = '{1'b1, 1'b1, 1'b0};
    localparam bit          CFG_WR   [3] = '{1'b1, 1'b1, 1'b0};
    localparam logic [31:0] CFG_INIT [3] = '{32'hA5A5_0000, 32'h0000_0000, 32'h1111_2222};

    typedef struct {
        int          lat;
        logic [1:0]  status;
        logic [31:0] rdata;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req      [3];
    logic [15:0] addr     [3];
    logic        dir      [3];
    logic [31:0] wdata    [3];
    logic [3:0]  strb     [3];
    logic        sel      [3];
    logic        rdy      [3];
    logic [31:0] rdata    [3];
    logic [1:0]  stat     [3];
    logic [31:0] val      [3];
    logic        hw_we    [3];
    logic [31:0] hw_data  [3];
    logic [31:0] oval     [3];

    logic [31:0] m_val [3];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rggen_register_responder #(
        .START_ADDRESS(16'h0010), .WAIT_CYCLES(0), .READABLE(1'b1), .WRITABLE(1'b1),
        .INITIAL_VALUE(32'hA5A5_0000)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .request(req[0]), .address(addr[0]), .direction(dir[0]),
        .write_data(wdata[0]), .write_strobe(strb[0]), .select(sel[0]), .ready(rdy[0]),
        .read_data(rdata[0]), .status(stat[0]), .value(val[0]), .i_hw_write(hw_we[0]),
        .i_hw_write_data(hw_data[0]), .o_value(oval[0])
    );

    rggen_register_responder #(
        .START_ADDRESS(16'h0020), .WAIT_CYCLES(3), .READABLE(1'b1), .WRITABLE(1'b1),
        .INITIAL_VALUE(32'h0000_0000)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .request(req[1]), .address(addr[1]), .direction(dir[1]),
        .write_data(wdata[1]), .write_strobe(strb[1]), .select(sel[1]), .ready(rdy[1]),
        .read_data(rdata[1]), .status(stat[1]), .value(val[1]), .i_hw_write(hw_we[1]),
        .i_hw_write_data(hw_data[1]), .o_value(oval[1])
    );

    rggen_register_responder #(
        .START_ADDRESS(16'h0030), .WAIT_CYCLES(0), .READABLE(1'b0), .WRITABLE(1'b0),
        .INITIAL_VALUE(32'h1111_2222)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .request(req[2]), .address(addr[2]), .direction(dir[2]),
        .write_data(wdata[2]), .write_strobe(strb[2]), .select(sel[2]), .ready(rdy[2]),
        .read_data(rdata[2]), .status(stat[2]), .value(val[2]), .i_hw_write(hw_we[2]),
        .i_hw_write_data(hw_data[2]), .o_value(oval[2])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one bus transaction; optionally fire a hw write on the commit edge.
    task automatic xfer(input int idx, input logic [15:0] a, input logic d,
                        input logic [31:0] wd, input logic [3:0] s,
                        input logic hw, input logic [31:0] hwd);
        exp_t        e;
        exp_t        got;
        logic        err;
        logic [31:0] nv;
        int          n;
        err      = d ? !CFG_WR[idx] : !CFG_RD[idx];
        e.lat    = CFG_WAIT[idx] + 1;
        e.status = err ? SERR : OKAY;
        e.rdata  = (!d && !err) ? m_val[idx] : 32'h0;
        nv       = hw ? hwd : m_val[idx];
        if (d && !err)
            for (int b = 0; b < 4; b++)
                if (s[b]) nv[8*b +: 8] = wd[8*b +: 8];
        e.value = nv;
        sb.push_back(e);

        @(negedge clk);
        req[idx] = 1'b1; addr[idx] = a; dir[idx] = d; wdata[idx] = wd; strb[idx] = s;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[idx] && n < 50);
        req[idx] = 1'b0;
        if (hw) begin
            hw_we[idx] = 1'b1; hw_data[idx] = hwd;
        end
        got = sb.pop_front();
        chk("latency", n, got.lat);
        chk("status", {30'h0, stat[idx]}, {30'h0, got.status});
        chk("read_data", rdata[idx], got.rdata);
        @(negedge clk);
        hw_we[idx] = 1'b0;
        m_val[idx] = got.value;
        chk("value", val[idx], got.value);
        chk("o_value", oval[idx], got.value);
        chk("ready_one_cycle", {31'h0, rdy[idx]}, 32'h0);
    endtask

    // Request that must not be decoded: no select, no ready.
    task automatic miss(input int idx, input logic [15:0] a);
        @(negedge clk);
        req[idx] = 1'b1; addr[idx] = a; dir[idx] = RD;
        #1 chk("select_miss", {31'h0, sel[idx]}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ready", {31'h0, rdy[idx]}, 32'h0);
        end
        req[idx] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; addr[i] = '0; dir[i] = RD; wdata[i] = '0; strb[i] = '0;
            hw_we[i] = 1'b0; hw_data[i] = '0; m_val[i] = CFG_INIT[i];
        end
        #12;
        chk("rst_value0", val[0], 32'hA5A5_0000);
        chk("rst_ready0", {31'h0, rdy[0]}, 32'h0);
        chk("rst_status0", {30'h0, stat[0]}, {30'h0, OKAY});
        chk("rst_rdata0", rdata[0], 32'h0);
        chk("rst_value2", val[2], 32'h1111_2222);
        @(negedge clk);
        rst_n = 1'b1;

        // zero wait: full write then read back
        xfer(0, 16'h0010, WR, 32'h1234_5678, 4'hF, 1'b0, '0);
        xfer(0, 16'h0010, RD, '0, 4'h0, 1'b0, '0);

        // three wait states, partial strobe
        xfer(1, 16'h0020, WR, 32'hFFFF_FFFF, 4'b0101, 1'b0, '0);
        chk("strobe_value", val[1], 32'h00FF_00FF);
        xfer(1, 16'h0020, RD, '0, 4'h0, 1'b0, '0);

        // disabled directions
        xfer(2, 16'h0030, RD, '0, 4'h0, 1'b0, '0);
        xfer(2, 16'h0030, WR, 32'hDEAD_BEEF, 4'hF, 1'b0, '0);

        // decode: next word and a foreign address miss, byte offset hits
        miss(0, 16'h0014);
        miss(0, 16'h0100);
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 16'h0011;
        #1 chk("select_offset", {31'h0, sel[0]}, 32'h1);
        req[0] = 1'b0;
        xfer(0, 16'h0011, WR, 32'h0BAD_F00D, 4'hF, 1'b0, '0);

        // standalone hw write
        @(negedge clk);
        hw_we[0] = 1'b1; hw_data[0] = 32'h5555_AAAA;
        @(negedge clk);
        hw_we[0] = 1'b0; m_val[0] = 32'h5555_AAAA;
        chk("hw_write", val[0], 32'h5555_AAAA);

        // bus write and hw write on the same edge
        xfer(0, 16'h0010, WR, 32'h0000_BEEF, 4'h3, 1'b1, 32'hCAFE_0000);
        chk("merge_value", val[0], 32'hCAFE_BEEF);

        // reset while u1 sits in wait states
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 16'h0020; dir[1] = WR; wdata[1] = 32'h1234_1234; strb[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_val[0] = CFG_INIT[0]; m_val[1] = CFG_INIT[1];
        chk("abort_value1", val[1], 32'h0);
        chk("abort_value0", val[0], 32'hA5A5_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_ready", {31'h0, rdy[1]}, 32'h0);
        end
        xfer(1, 16'h0020, RD, '0, 4'h0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
